// File: rtl/uart_pkg.sv
// Shared types and helpers for the parametrised UART transmitter.
// Holds the shift FSM encoding, parity mode encodings and the parity function.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_PAR   = 3'd3,
    ST_STOP  = 3'd4
  } state_t;

  localparam logic [1:0] PAR_NONE = 2'd0;
  localparam logic [1:0] PAR_ODD  = 2'd1;
  localparam logic [1:0] PAR_EVEN = 2'd2;

  // Callers zero-extend their word; the extra zeros do not change the XOR.
  function automatic logic par_bit(input logic [15:0] data, input logic [1:0] mode);
    logic x;
    x = ^data;
    case (mode)
      PAR_ODD:  par_bit = ~x;
      PAR_EVEN: par_bit = x;
      default:  par_bit = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period down-counter: bit_end marks the last cycle of each bit period.
// Reloaded with div-1 on load (frame start) and at every bit boundary.
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [DIV_W-1:0] div,
  output logic             bit_end
);

  logic [DIV_W-1:0] cnt;

  assign bit_end = (cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load || bit_end) begin
      cnt <= div - 1'b1;
    end else begin
      cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmitter with configurable data width, parity and stop bits,
// a per-frame runtime baud divisor and a one-word holding buffer.
//
// Stream handshake: a word transfers on any rising edge where s_valid and
// s_ready are both high; s_ready is high exactly when the holding buffer is
// empty, and s_data is only sampled on that transfer edge.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int CLK_SPEED = 100_000_000,
  parameter int BAUD      = 115200,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1,
  parameter int DIV_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [DATA_BITS-1:0] s_data,
  input  logic [DIV_W-1:0]     baud_div,
  output logic                 tx,
  output logic                 tx_busy
);

  localparam int DEF_DIV = CLK_SPEED / BAUD;
  localparam int CNT_W   = $clog2(DATA_BITS + 1);

  state_t               state;
  logic [DATA_BITS-1:0] shift;
  logic [DATA_BITS-1:0] buf_data;
  logic                 buf_full;
  logic [CNT_W-1:0]     bit_cnt;
  logic                 stop_cnt;
  logic                 par_q;
  logic [DIV_W-1:0]     div_q;

  logic [DIV_W-1:0]     eff_div;
  logic [DIV_W-1:0]     timer_div;
  logic                 bit_end;
  logic                 last_stop;
  logic                 frame_start;
  logic                 accept;

  assign eff_div     = (baud_div == '0) ? DIV_W'(DEF_DIV) : baud_div;
  assign last_stop   = (state == ST_STOP) && bit_end && (stop_cnt == 1'(STOP_BITS - 1));
  assign frame_start = buf_full && ((state == ST_IDLE) || last_stop);
  assign accept      = s_valid && !buf_full;

  // In IDLE the timer is fed a divisor of 1 so it parks at zero.
  assign timer_div = frame_start         ? eff_div :
                     (state == ST_IDLE)  ? DIV_W'(1) : div_q;

  assign s_ready = !buf_full;
  assign tx_busy = (state != ST_IDLE) || buf_full;

  uart_bit_timer #(
    .DIV_W (DIV_W)
  ) u_bit_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (frame_start),
    .div     (timer_div),
    .bit_end (bit_end)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      tx       <= 1'b1;
      shift    <= '0;
      buf_data <= '0;
      buf_full <= 1'b0;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
      par_q    <= 1'b0;
      div_q    <= DIV_W'(DEF_DIV);
    end else begin
      if (frame_start) begin
        state    <= ST_START;
        tx       <= 1'b0;
        shift    <= buf_data;
        par_q    <= par_bit(16'(buf_data), 2'(PARITY));
        div_q    <= eff_div;
        bit_cnt  <= '0;
        stop_cnt <= 1'b0;
        buf_full <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            tx <= 1'b1;
          end
          ST_START: begin
            if (bit_end) begin
              state   <= ST_DATA;
              tx      <= shift[0];
              shift   <= shift >> 1;
              bit_cnt <= '0;
            end
          end
          ST_DATA: begin
            if (bit_end) begin
              if (bit_cnt == CNT_W'(DATA_BITS - 1)) begin
                if (PARITY != 0) begin
                  state <= ST_PAR;
                  tx    <= par_q;
                end else begin
                  state    <= ST_STOP;
                  tx       <= 1'b1;
                  stop_cnt <= 1'b0;
                end
              end else begin
                tx      <= shift[0];
                shift   <= shift >> 1;
                bit_cnt <= bit_cnt + 1'b1;
              end
            end
          end
          ST_PAR: begin
            if (bit_end) begin
              state    <= ST_STOP;
              tx       <= 1'b1;
              stop_cnt <= 1'b0;
            end
          end
          ST_STOP: begin
            tx <= 1'b1;
            if (bit_end) begin
              // A full buffer at this point is handled by frame_start above.
              if (stop_cnt == 1'(STOP_BITS - 1)) begin
                state <= ST_IDLE;
              end else begin
                stop_cnt <= 1'b1;
              end
            end
          end
          default: begin
            state <= ST_IDLE;
            tx    <= 1'b1;
          end
        endcase
      end

      // Placed last so a same-edge refill wins over the frame-start empty.
      if (accept) begin
        buf_data <= s_data;
        buf_full <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: three configurations (8N1, 7E1, 7O2) share one clock,
// reset and divisor; per-instance monitors check every cycle of every frame.
module tb_uart_tx_frame;

  logic        clk;
  logic        rst_n;
  logic [15:0] baud_div;

  logic       s_valid0, s_ready0, tx0, tx_busy0;
  logic [7:0] s_data0;
  logic       s_valid1, s_ready1, tx1, tx_busy1;
  logic [6:0] s_data1;
  logic       s_valid2, s_ready2, tx2, tx_busy2;
  logic [6:0] s_data2;

  int compared;
  int mismatched;
  int last_gap [3];
  int busy_run;
  int last_run;
  bit run_started;

  // Each entry: {divisor[15:0], expected frame bits LSB-first[15:0]}.
  logic [31:0] exp_q0[$];
  logic [31:0] exp_q1[$];
  logic [31:0] exp_q2[$];

  uart_tx_frame #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .DIV_W(16)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid0), .s_ready(s_ready0), .s_data(s_data0),
    .baud_div(baud_div), .tx(tx0), .tx_busy(tx_busy0));

  uart_tx_frame #(.DATA_BITS(7), .PARITY(2), .STOP_BITS(1), .DIV_W(16)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid1), .s_ready(s_ready1), .s_data(s_data1),
    .baud_div(baud_div), .tx(tx1), .tx_busy(tx_busy1));

  uart_tx_frame #(.DATA_BITS(7), .PARITY(1), .STOP_BITS(2), .DIV_W(16)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid2), .s_ready(s_ready2), .s_data(s_data2),
    .baud_div(baud_div), .tx(tx2), .tx_busy(tx_busy2));

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  function automatic logic tx_of(input int idx);
    case (idx)
      1:       return tx1;
      2:       return tx2;
      default: return tx0;
    endcase
  endfunction

  function automatic logic ready_of(input int idx);
    case (idx)
      1:       return s_ready1;
      2:       return s_ready2;
      default: return s_ready0;
    endcase
  endfunction

  function automatic logic busy_of(input int idx);
    case (idx)
      1:       return tx_busy1;
      2:       return tx_busy2;
      default: return tx_busy0;
    endcase
  endfunction

  function automatic int nbits(input int idx);
    case (idx)
      1:       return 10;
      2:       return 11;
      default: return 10;
    endcase
  endfunction

  // Frame image: start 0, data LSB first, optional parity, stop ones above.
  function automatic logic [15:0] mk(input int idx, input logic [8:0] data, input logic par);
    logic [15:0] bits;
    int db;
    db = (idx == 0) ? 8 : 7;
    bits = '1;
    bits[0] = 1'b0;
    for (int i = 0; i < db; i++) bits[1+i] = data[i];
    if (idx != 0) bits[1+db] = par;
    return bits;
  endfunction

  function automatic int q_size(input int idx);
    case (idx)
      1:       return exp_q1.size();
      2:       return exp_q2.size();
      default: return exp_q0.size();
    endcase
  endfunction

  task automatic push_exp(input int idx, input logic [31:0] v);
    case (idx)
      1:       exp_q1.push_back(v);
      2:       exp_q2.push_back(v);
      default: exp_q0.push_back(v);
    endcase
  endtask

  task automatic pop_exp(input int idx, output logic [31:0] v);
    case (idx)
      1:       v = exp_q1.pop_front();
      2:       v = exp_q2.pop_front();
      default: v = exp_q0.pop_front();
    endcase
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, exp);
    end
  endtask

  // ---------------- driver ----------------
  task automatic send(input int idx, input logic [8:0] data, input logic par, input int d);
    int t;
    t = 0;
    @(negedge clk);
    while (!ready_of(idx) && t < 20000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 20000) begin
      compared++;
      mismatched++;
      $display("FAIL send_timeout dut%0d: s_ready stayed 0, required 1", idx);
      return;
    end
    push_exp(idx, {d[15:0], mk(idx, data, par)});
    case (idx)
      1:       begin s_valid1 = 1'b1; s_data1 = data[6:0]; end
      2:       begin s_valid2 = 1'b1; s_data2 = data[6:0]; end
      default: begin s_valid0 = 1'b1; s_data0 = data[7:0]; end
    endcase
    @(posedge clk);
    #1;
    s_valid0 = 1'b0;
    s_valid1 = 1'b0;
    s_valid2 = 1'b0;
  endtask

  task automatic wait_idle(input int idx);
    int t;
    t = 0;
    @(negedge clk);
    while ((q_size(idx) != 0 || busy_of(idx)) && t < 30000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 30000) begin
      compared++;
      mismatched++;
      $display("FAIL idle_timeout dut%0d: still busy, required idle", idx);
    end
    repeat (2) @(negedge clk);
  endtask

  // ---------------- monitor / scoreboard ----------------
  task automatic mon(input int idx);
    logic [31:0] e;
    logic [15:0] bits, got;
    int d, n, idle_run, t;
    bit bad, aborted;
    idle_run = 100000;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        idle_run = 100000;
        continue;
      end
      if (tx_of(idx) == 1'b1) begin
        idle_run++;
        continue;
      end
      last_gap[idx] = idle_run;
      idle_run = 0;
      if (q_size(idx) == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_start dut%0d: start bit seen, required no frame", idx);
        t = 0;
        while (tx_of(idx) == 1'b0 && t < 20000) begin
          @(negedge clk);
          t++;
        end
        continue;
      end
      pop_exp(idx, e);
      bits = e[15:0];
      d = int'(e[31:16]);
      n = nbits(idx);
      bad = 1'b0;
      aborted = 1'b0;
      got = '1;
      for (int b = 0; b < n && !aborted; b++) begin
        for (int c = 0; c < d && !aborted; c++) begin
          if (b != 0 || c != 0) @(negedge clk);
          if (!rst_n) begin
            aborted = 1'b1;
          end else begin
            if (tx_of(idx) !== bits[b]) bad = 1'b1;
            if (c == d - 1) got[b] = tx_of(idx);
          end
        end
      end
      if (aborted) begin
        idle_run = 100000;
        continue;
      end
      compared++;
      if (bad) begin
        mismatched++;
        $display("FAIL frame dut%0d div=%0d: got bits 0x%04h, required 0x%04h (each bit held %0d cycles)",
                 idx, d, got, bits, d);
      end
    end
  endtask

  initial mon(0);
  initial mon(1);
  initial mon(2);

  // Busy-run length of dut0 counted from its first start-bit cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      busy_run = 0;
      run_started = 1'b0;
    end else if (tx_busy0) begin
      if (tx0 == 1'b0) run_started = 1'b1;
      if (run_started) busy_run++;
    end else begin
      if (busy_run != 0) last_run = busy_run;
      busy_run = 0;
      run_started = 1'b0;
    end
  end

  // ---------------- directed tests ----------------
  initial begin
    int lows;
    compared = 0;
    mismatched = 0;
    last_run = 0;
    busy_run = 0;
    run_started = 1'b0;
    for (int i = 0; i < 3; i++) last_gap[i] = 100000;
    rst_n = 1'b0;
    baud_div = 16'd4;
    s_valid0 = 1'b1; s_data0 = 8'hFF;
    s_valid1 = 1'b0; s_data1 = '0;
    s_valid2 = 1'b0; s_data2 = '0;

    // Reset with s_valid held high: nothing may be accepted.
    repeat (5) @(negedge clk);
    chk("reset_tx", tx0, 1'b1);
    chk("reset_busy", tx_busy0, 1'b0);
    chk("reset_ready", s_ready0, 1'b1);
    s_valid0 = 1'b0;
    #2 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_reset_busy", tx_busy0, 1'b0);

    // 8N1, div 4, 0xA5: one buffer-full cycle, then a 40-cycle frame.
    last_run = 0;
    send(0, 9'h0A5, 1'b0, 4);
    @(negedge clk);
    chk("latency_ready_low", s_ready0, 1'b0);
    chk("latency_busy", tx_busy0, 1'b1);
    chk("latency_tx_still_high", tx0, 1'b1);
    @(negedge clk);
    chk("latency_start_low", tx0, 1'b0);
    wait_idle(0);
    chk("a5_busy_cycles", last_run, 40);

    // Parity, 7 data bits, div 2.
    baud_div = 16'd2;
    send(1, 9'h055, 1'b0, 2);
    send(1, 9'h054, 1'b1, 2);
    wait_idle(1);
    send(2, 9'h055, 1'b1, 2);
    wait_idle(2);

    // Back-to-back, div 3: second word offered during the first start bit.
    baud_div = 16'd3;
    last_run = 0;
    send(0, 9'h000, 1'b0, 3);
    @(negedge clk);
    chk("b2b_ready_drop", s_ready0, 1'b0);
    @(negedge clk);
    chk("b2b_ready_rise", s_ready0, 1'b1);
    chk("b2b_in_start", tx0, 1'b0);
    send(0, 9'h0FF, 1'b0, 3);
    wait_idle(0);
    chk("b2b_gap", last_gap[0], 0);
    chk("b2b_busy_cycles", last_run, 60);

    // One-cycle bits.
    baud_div = 16'd1;
    send(0, 9'h0C3, 1'b0, 1);
    wait_idle(0);

    // Divisor 0 selects the default of 868.
    baud_div = 16'd0;
    send(0, 9'h055, 1'b0, 868);
    wait_idle(0);

    // Divisor change mid-frame: frame keeps 4, the buffered word uses 8.
    baud_div = 16'd4;
    send(0, 9'h081, 1'b0, 4);
    send(0, 9'h07E, 1'b0, 8);
    repeat (8) @(posedge clk);
    #1 baud_div = 16'd8;
    wait_idle(0);

    // Reset during data bit 3 with a word pending in the buffer.
    baud_div = 16'd4;
    send(0, 9'h00F, 1'b0, 4);
    send(0, 9'h0F0, 1'b0, 4);
    repeat (16) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midreset_tx", tx0, 1'b1);
    chk("midreset_busy", tx_busy0, 1'b0);
    chk("midreset_ready", s_ready0, 1'b1);
    exp_q0.delete();
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    lows = 0;
    repeat (60) begin
      @(negedge clk);
      if (tx0 == 1'b0 || tx_busy0) lows++;
    end
    chk("pending_word_dropped", lows, 0);
    send(0, 9'h03C, 1'b0, 4);
    wait_idle(0);

    chk("leftover_q0", exp_q0.size(), 0);
    chk("leftover_q1", exp_q1.size(), 0);
    chk("leftover_q2", exp_q2.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
